// File: rtl/load_unit.sv
// RV32 load engine: accepts one load from execute, reads a word from data memory
// over req/ready + rvalid, then aligns and sign/zero-extends it for writeback.
module load_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  input  logic [4:0]            ld_rd,
  output logic                  busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  ld_fault,
  output logic [1:0]            dbgState
);

  // Handshake: a read is accepted on the cycle mem_req && mem_ready; its data is
  // taken on the first mem_rvalid seen in S_WAIT. rvalid outside S_WAIT is dropped.

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } stateT;

  stateT         state, stateNext;
  logic [1:0]    addrLo;
  logic [2:0]    funct3Q;
  logic [4:0]    rdQ;
  logic [CW-1:0] waitCnt;

  logic          reqBad;
  logic          acceptLd;
  logic          captureData;
  logic          faultNow;
  logic [7:0]    selByte;
  logic [15:0]   selHalf;
  logic [31:0]   alignedData;

  always_comb begin
    reqBad = 1'b0;
    case (ld_funct3)
      3'b011, 3'b110, 3'b111: reqBad = 1'b1;
      3'b001, 3'b101:         reqBad = ld_addr[0];
      3'b010:                 reqBad = (ld_addr[1:0] != 2'b00);
      default:                reqBad = 1'b0;
    endcase
  end

  always_comb begin
    selByte = 8'h00;
    case (addrLo)
      2'd0:    selByte = mem_rdata[7:0];
      2'd1:    selByte = mem_rdata[15:8];
      2'd2:    selByte = mem_rdata[23:16];
      default: selByte = mem_rdata[31:24];
    endcase
    selHalf = addrLo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3Q)
      3'b000:  alignedData = {{24{selByte[7]}}, selByte};
      3'b100:  alignedData = {24'h000000, selByte};
      3'b001:  alignedData = {{16{selHalf[15]}}, selHalf};
      3'b101:  alignedData = {16'h0000, selHalf};
      default: alignedData = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    busy        = (state != S_IDLE);
    mem_req     = (state == S_REQ);
    acceptLd    = 1'b0;
    captureData = 1'b0;
    faultNow    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_valid) begin
          if (reqBad) begin
            faultNow = 1'b1;
          end else begin
            acceptLd  = 1'b1;
            stateNext = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) stateNext = S_WAIT;
      end
      S_WAIT: begin
        // rvalid takes priority over the timeout on the final cycle
        if (mem_rvalid) begin
          captureData = 1'b1;
          stateNext   = S_RESP;
        end else if (waitCnt == CNT_LAST) begin
          faultNow  = 1'b1;
          stateNext = S_IDLE;
        end
      end
      S_RESP: stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrLo   <= 2'b00;
      funct3Q  <= 3'b000;
      rdQ      <= 5'd0;
      waitCnt  <= '0;
      mem_addr <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'h0;
      ld_fault <= 1'b0;
    end else begin
      wb_valid <= captureData;
      ld_fault <= faultNow;
      if (acceptLd) begin
        addrLo   <= ld_addr[1:0];
        funct3Q  <= ld_funct3;
        rdQ      <= ld_rd;
        mem_addr <= {ld_addr[ADDR_WIDTH-1:2], 2'b00};
      end
      if (state == S_WAIT) waitCnt <= waitCnt + 1'b1;
      else                 waitCnt <= '0;
      if (captureData) begin
        wb_data <= alignedData;
        wb_rd   <= rdQ;
      end
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_load_unit.sv
// Randomized bench for load_unit with a transaction-level reference model:
// directed alignment/fault/timeout/reset cases, then random loads.
module tb_load_unit;

  localparam int AW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_funct3;
  logic [4:0]    ld_rd;
  logic          busy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          ld_fault;
  logic [1:0]    dbgState;

  load_unit #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .ld_rd(ld_rd), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_fault(ld_fault), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastData = 32'h0;
  logic [31:0] lastRd   = 32'h0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit refFault(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off = addr % 4;
    case (f3)
      3, 6, 7: return 1'b1;
      1, 5:    return (off % 2) != 0;
      2:       return off != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refData(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    int unsigned off = addr % 4;
    logic [31:0] bv = (rdata / (32'd1 << (off * 8))) % 256;
    logic [31:0] hv = (rdata / (32'd1 << ((off / 2) * 16))) % 65536;
    case (f3)
      0:       return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
      4:       return bv;
      1:       return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
      5:       return hv;
      default: return rdata;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full load transaction. rvalidDly >= TMO means rvalid is withheld.
  task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                        input int readyDly, input int rvalidDly, input logic [31:0] rdata,
                        input bit stray);
    checkVal("idle_busy", 32'(busy), 32'd0);
    ld_valid = 1'b1; ld_addr = addr; ld_funct3 = f3; ld_rd = rd;
    step();
    ld_valid = 1'b0; ld_addr = $urandom; ld_funct3 = 3'($urandom_range(0, 7));
    if (refFault(f3, addr)) begin
      checkVal("bad_fault", 32'(ld_fault), 32'd1);
      checkVal("bad_busy", 32'(busy), 32'd0);
      checkVal("bad_req", 32'(mem_req), 32'd0);
      step();
      checkVal("bad_fault_end", 32'(ld_fault), 32'd0);
      checkVal("bad_req2", 32'(mem_req), 32'd0);
      return;
    end
    checkVal("req_busy", 32'(busy), 32'd1);
    checkVal("req_mem_req", 32'(mem_req), 32'd1);
    checkVal("req_addr", mem_addr, addr - (addr % 4));
    for (int i = 0; i < readyDly; i++) begin
      mem_rvalid = stray;
      step();
      checkVal("req_hold", 32'(mem_req), 32'd1);
    end
    mem_ready = 1'b1; mem_rvalid = stray;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    checkVal("wait_req", 32'(mem_req), 32'd0);
    checkVal("wait_busy", 32'(busy), 32'd1);
    checkVal("wait_wb", 32'(wb_valid), 32'd0);
    if (rvalidDly < TMO) begin
      for (int i = 0; i < rvalidDly; i++) begin
        step();
        checkVal("wait_nofault", 32'(ld_fault), 32'd0);
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      expQ.push_back(refData(f3, addr, rdata));
      checkVal("resp_wb_valid", 32'(wb_valid), 32'd1);
      checkVal("resp_busy", 32'(busy), 32'd1);
      checkVal("resp_rd", 32'(wb_rd), 32'(rd));
      if (expQ.size() > 0) begin
        lastData = expQ.pop_front();
        checkVal("resp_data", wb_data, lastData);
      end
      lastRd = 32'(rd);
      step();
      checkVal("done_wb_valid", 32'(wb_valid), 32'd0);
      checkVal("done_busy", 32'(busy), 32'd0);
      checkVal("done_hold", wb_data, lastData);
    end else begin
      for (int i = 0; i < TMO - 1; i++) begin
        step();
        checkVal("tmo_early", 32'(ld_fault), 32'd0);
      end
      step();
      checkVal("tmo_fault", 32'(ld_fault), 32'd1);
      checkVal("tmo_wb", 32'(wb_valid), 32'd0);
      checkVal("tmo_busy", 32'(busy), 32'd0);
      checkVal("tmo_hold_data", wb_data, lastData);
      checkVal("tmo_hold_rd", 32'(wb_rd), lastRd);
      step();
      checkVal("tmo_pulse", 32'(ld_fault), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = 3'b0; ld_rd = 5'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step(); step();
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_req", 32'(mem_req), 32'd0);
    checkVal("rst_wb", 32'(wb_valid), 32'd0);
    checkVal("rst_fault", 32'(ld_fault), 32'd0);
    checkVal("rst_addr", mem_addr, 32'h0);
    checkVal("rst_data", wb_data, 32'h0);
    reset = 1'b0;
    step();

    doLoad(3'b010, 32'h100, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0);
    doLoad(3'b000, 32'h103, 5'd6, 0, 1, 32'h80FF1234, 1'b0);
    checkVal("lb_direct", wb_data, 32'hFFFFFF80);
    doLoad(3'b100, 32'h103, 5'd7, 1, 0, 32'h80FF1234, 1'b1);
    checkVal("lbu_direct", wb_data, 32'h00000080);
    doLoad(3'b001, 32'h102, 5'd8, 0, 0, 32'h80017FFF, 1'b0);
    checkVal("lh_direct", wb_data, 32'hFFFF8001);
    doLoad(3'b101, 32'h102, 5'd9, 2, 2, 32'h80017FFF, 1'b0);
    checkVal("lhu_direct", wb_data, 32'h00008001);
    doLoad(3'b001, 32'h000, 5'd10, 0, 0, 32'h00007FFF, 1'b0);
    checkVal("lh_pos_direct", wb_data, 32'h00007FFF);

    doLoad(3'b010, 32'h102, 5'd1, 0, 0, 32'h0, 1'b0);
    doLoad(3'b001, 32'h101, 5'd1, 0, 0, 32'h0, 1'b0);
    doLoad(3'b011, 32'h100, 5'd1, 0, 0, 32'h0, 1'b0);
    checkVal("fault_keeps_data", wb_data, 32'h00007FFF);

    doLoad(3'b010, 32'h200, 5'd11, 10, TMO, 32'h0, 1'b1);
    doLoad(3'b010, 32'h204, 5'd12, 0, TMO - 1, 32'hCAFEF00D, 1'b0);
    checkVal("late_rvalid_wins", wb_data, 32'hCAFEF00D);
    doLoad(3'b000, 32'h301, 5'd0, 0, 0, 32'h0000_7F00, 1'b0);

    // reset in the middle of WAIT, stale rvalid afterwards
    ld_valid = 1'b1; ld_addr = 32'h400; ld_funct3 = 3'b010; ld_rd = 5'd3;
    step();
    ld_valid = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    #2;
    checkVal("mid_rst_busy", 32'(busy), 32'd0);
    checkVal("mid_rst_data", wb_data, 32'h0);
    checkVal("mid_rst_rd", 32'(wb_rd), 32'd0);
    checkVal("mid_rst_addr", mem_addr, 32'h0);
    step();
    reset = 1'b0;
    step(); step();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_rvalid = 1'b0;
    checkVal("stale_wb", 32'(wb_valid), 32'd0);
    checkVal("stale_busy", 32'(busy), 32'd0);
    checkVal("stale_data", wb_data, 32'h0);
    lastData = 32'h0; lastRd = 32'h0;
    step();
    doLoad(3'b010, 32'h500, 5'd4, 0, 0, 32'hA5A55A5A, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3 = 3'($urandom_range(0, 7));
      logic [31:0] ad = $urandom % 32'h10000;
      int          rv = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 5);
      doLoad(f3, ad, 5'($urandom_range(0, 31)), $urandom_range(0, 3), rv, $urandom,
             1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
